i2c_apb_regs: RTL and testbench

- APB slave register file for the I2C controller, directly downstream of the button-driven APB master.
- Decodes single-cycle APB accesses (psel and penable asserted together for one cycle, no pready).
- Holds control, prescale and slave-address registers.
- Buffers TX bytes into the I2C core and RX bytes out of it through two FIFOs. DATA register 0x0C is the FIFO window.

---
 rtl/i2c_apb_regs_pkg.sv | 28 ++
 rtl/i2c_sync_fifo.sv | 48 ++++
 rtl/i2c_apb_regs.sv | 141 ++++++++++++++
 tb/tb_i2c_apb_regs.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_apb_regs_pkg.sv
// Shared register offsets, bit indices and reset constants for the I2C APB register file.
package i2c_apb_regs_pkg;

   localparam logic [6:0] ADDR_CTRL     = 7'h00;
   localparam logic [6:0] ADDR_STATUS   = 7'h04;
   localparam logic [6:0] ADDR_PRESCALE = 7'h08;
   localparam logic [6:0] ADDR_DATA     = 7'h0C;
   localparam logic [6:0] ADDR_IRQ_EN   = 7'h10;
   localparam logic [6:0] ADDR_IRQ_STAT = 7'h14;
   localparam logic [6:0] ADDR_SLV_ADDR = 7'h2C;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_START = 1;
   localparam int CTRL_STOP  = 2;
   localparam int CTRL_RW    = 3;

   localparam int STAT_TX_EMPTY = 0;
   localparam int STAT_TX_FULL  = 1;
   localparam int STAT_RX_EMPTY = 2;
   localparam int STAT_RX_FULL  = 3;
   localparam int STAT_BUSY     = 4;
   localparam int STAT_ACK_ERR  = 5;
   localparam int STAT_TX_OVF   = 6;
   localparam int STAT_RX_OVF   = 7;

   localparam logic [15:0] PRESCALE_RST = 16'h0063;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO succeeds only alongside a pop.
module i2c_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             pclk,
   input  logic             prst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign ovf     = push & ~do_push;
   assign head    = mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (prst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge pclk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/i2c_apb_regs.sv
// APB register file for the I2C controller: CTRL, STATUS, PRESCALE, DATA (FIFO window), SLV_ADDR.
// Define I2C_REGS_IRQ_EN to add IRQ_EN/IRQ_STAT and a registered interrupt output.
module i2c_apb_regs #(
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [15:0] PRESCALE_RST = 16'h0063
) (
   input  logic        pclk,
   input  logic        prst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        core_busy,
   input  logic        core_ack_err,
   output logic        ctrl_en,
   output logic        ctrl_start,
   output logic        ctrl_stop,
   output logic        ctrl_rw,
   output logic [15:0] prescale,
   output logic [6:0]  slv_addr,
   output logic        irq
);

   import i2c_apb_regs_pkg::*;

   logic [6:0] addr;
   logic       wr_acc, rd_acc;
   logic       wr_ctrl, wr_status, wr_presc, wr_data, wr_slv, rd_data;
   logic       tx_full, tx_empty, tx_ovf_evt;
   logic       rx_full, rx_empty, rx_ovf_evt;
   logic [7:0] rx_head;
   logic       ack_err, tx_ovf, rx_ovf;
   logic [7:0] status;
   logic       unused_bits;

   assign addr      = paddr[6:0];
   assign wr_acc    = psel & penable & pwrite;
   assign rd_acc    = psel & penable & ~pwrite;
   assign wr_ctrl   = wr_acc && (addr == ADDR_CTRL);
   assign wr_status = wr_acc && (addr == ADDR_STATUS);
   assign wr_presc  = wr_acc && (addr == ADDR_PRESCALE);
   assign wr_data   = wr_acc && (addr == ADDR_DATA);
   assign wr_slv    = wr_acc && (addr == ADDR_SLV_ADDR);
   assign rd_data   = rd_acc && (addr == ADDR_DATA);
   assign unused_bits = ^{paddr[31:7], pwdata[31:16]};

   i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .pclk(pclk), .prst(prst), .push(wr_data), .wdata(pwdata[7:0]), .pop(tx_ready),
      .head(tx_data), .full(tx_full), .empty(tx_empty), .ovf(tx_ovf_evt)
   );

   i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .pclk(pclk), .prst(prst), .push(rx_valid), .wdata(rx_data), .pop(rd_data),
      .head(rx_head), .full(rx_full), .empty(rx_empty), .ovf(rx_ovf_evt)
   );

   assign tx_valid = ~tx_empty;

   // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
   always_ff @(posedge pclk) begin
      if (prst) begin
         ctrl_en    <= 1'b0;
         ctrl_rw    <= 1'b0;
         ctrl_start <= 1'b0;
         ctrl_stop  <= 1'b0;
         prescale   <= PRESCALE_RST;
         slv_addr   <= '0;
         ack_err    <= 1'b0;
         tx_ovf     <= 1'b0;
         rx_ovf     <= 1'b0;
      end else begin
         ctrl_start <= wr_ctrl & pwdata[CTRL_START];
         ctrl_stop  <= wr_ctrl & pwdata[CTRL_STOP];
         if (wr_ctrl) begin
            ctrl_en <= pwdata[CTRL_EN];
            ctrl_rw <= pwdata[CTRL_RW];
         end
         if (wr_presc) prescale <= pwdata[15:0];
         if (wr_slv)   slv_addr <= pwdata[6:0];
         ack_err <= core_ack_err | (ack_err & ~(wr_status & pwdata[STAT_ACK_ERR]));
         tx_ovf  <= tx_ovf_evt   | (tx_ovf  & ~(wr_status & pwdata[STAT_TX_OVF]));
         rx_ovf  <= rx_ovf_evt   | (rx_ovf  & ~(wr_status & pwdata[STAT_RX_OVF]));
      end
   end

   always_comb begin
      status                = '0;
      status[STAT_TX_EMPTY] = tx_empty;
      status[STAT_TX_FULL]  = tx_full;
      status[STAT_RX_EMPTY] = rx_empty;
      status[STAT_RX_FULL]  = rx_full;
      status[STAT_BUSY]     = core_busy;
      status[STAT_ACK_ERR]  = ack_err;
      status[STAT_TX_OVF]   = tx_ovf;
      status[STAT_RX_OVF]   = rx_ovf;
   end

`ifdef I2C_REGS_IRQ_EN
   logic [3:0] irq_en;
   logic [3:0] irq_stat;

   assign irq_stat = {tx_ovf | rx_ovf, ack_err, ~rx_empty, tx_empty};

   always_ff @(posedge pclk) begin
      if (prst) begin
         irq_en <= '0;
         irq    <= 1'b0;
      end else begin
         if (wr_acc && (addr == ADDR_IRQ_EN)) irq_en <= pwdata[3:0];
         irq <= |(irq_en & irq_stat);
      end
   end
`else
   assign irq = 1'b0;
`endif

   // NOTE: prdata gets a default before the case so no path can infer a latch.
   always_comb begin
      prdata = '0;
      case (addr)
         ADDR_CTRL:     prdata = {28'b0, ctrl_rw, 2'b00, ctrl_en};
         ADDR_STATUS:   prdata = {24'b0, status};
         ADDR_PRESCALE: prdata = {16'b0, prescale};
         ADDR_DATA:     prdata = rx_empty ? 32'b0 : {24'b0, rx_head};
         ADDR_SLV_ADDR: prdata = {25'b0, slv_addr};
`ifdef I2C_REGS_IRQ_EN
         ADDR_IRQ_EN:   prdata = {28'b0, irq_en};
         ADDR_IRQ_STAT: prdata = {28'b0, irq_stat};
`endif
         default:       prdata = '0;
      endcase
   end

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Directed and randomized bench for i2c_apb_regs against a queue-based reference model.
module tb_i2c_apb_regs;

   localparam int DEPTH = 16;
   localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_PRESC = 32'h08;
   localparam logic [31:0] A_DATA = 32'h0C, A_IRQ_EN = 32'h10, A_IRQ_STAT = 32'h14;
   localparam logic [31:0] A_SLV  = 32'h2C;

   logic        pclk, prst, psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, core_busy, core_ack_err;
   logic        ctrl_en, ctrl_start, ctrl_stop, ctrl_rw, irq;
   logic [15:0] prescale;
   logic [6:0]  slv_addr;

   int errors = 0;
   int checks = 0;

   i2c_apb_regs #(.FIFO_DEPTH(DEPTH), .PRESCALE_RST(16'h0063)) dut (
      .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .core_busy(core_busy),
      .core_ack_err(core_ack_err), .ctrl_en(ctrl_en), .ctrl_start(ctrl_start),
      .ctrl_stop(ctrl_stop), .ctrl_rw(ctrl_rw), .prescale(prescale),
      .slv_addr(slv_addr), .irq(irq)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
      cyc();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
      #1;
      d = prdata;
      @(posedge pclk);
      #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic do_reset();
      prst = 1'b1;
      cyc();
      cyc();
      prst = 1'b0;
      #1;
   endtask

   // Reference model: FIFO contents as queues, sticky flags as bits.
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   bit m_ack, m_tx_ovf, m_rx_ovf;

   function automatic logic [31:0] exp_status();
      logic [7:0] s;
      s[0] = (tx_q.size() == 0);
      s[1] = (tx_q.size() == DEPTH);
      s[2] = (rx_q.size() == 0);
      s[3] = (rx_q.size() == DEPTH);
      s[4] = core_busy;
      s[5] = m_ack;
      s[6] = m_tx_ovf;
      s[7] = m_rx_ovf;
      return {24'b0, s};
   endfunction

   initial begin
      logic [31:0] rd;
      prst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      core_busy = 1'b0; core_ack_err = 1'b0;

      // Reset state
      do_reset();
      apb_read(A_STATUS, rd);   check("reset_status", rd, 32'h05);
      apb_read(A_PRESC, rd);    check("reset_presc", rd, 32'h0063);
      apb_read(A_CTRL, rd);     check("reset_ctrl", rd, 32'h0);
      apb_read(A_DATA, rd);     check("reset_data", rd, 32'h0);
      check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);

      // CTRL with start pulse
      apb_write(A_CTRL, 32'h0B);
      check("ctrl_en", {31'b0, ctrl_en}, 32'h1);
      check("ctrl_rw", {31'b0, ctrl_rw}, 32'h1);
      check("ctrl_start_hi", {31'b0, ctrl_start}, 32'h1);
      check("ctrl_stop_lo", {31'b0, ctrl_stop}, 32'h0);
      cyc();
      check("ctrl_start_lo", {31'b0, ctrl_start}, 32'h0);
      apb_read(A_CTRL, rd);     check("ctrl_read", rd, 32'h09);
      apb_write(A_CTRL, 32'h05);
      check("ctrl_stop_hi", {31'b0, ctrl_stop}, 32'h1);
      check("ctrl_rw_clr", {31'b0, ctrl_rw}, 32'h0);
      cyc();
      check("ctrl_stop_lo2", {31'b0, ctrl_stop}, 32'h0);

      // PRESCALE, SLV_ADDR, unmapped
      apb_write(A_PRESC, 32'h1234_ABCD);
      check("presc_out", {16'b0, prescale}, 32'hABCD);
      apb_read(32'hFFFF_FF88, rd); check("presc_alias", rd, 32'hABCD);
      apb_write(A_SLV, 32'hFFFF_FFFF);
      check("slv_out", {25'b0, slv_addr}, 32'h7F);
      apb_read(A_SLV, rd);      check("slv_read", rd, 32'h7F);
      apb_write(32'h30, 32'hFFFF_FFFF);
      apb_read(32'h30, rd);     check("unmapped", rd, 32'h0);
`ifndef I2C_REGS_IRQ_EN
      apb_write(A_IRQ_EN, 32'hF);
      apb_read(A_IRQ_EN, rd);   check("irq_en_unmapped", rd, 32'h0);
      apb_read(A_IRQ_STAT, rd); check("irq_stat_unmapped", rd, 32'h0);
`endif

      // TX fill past full, then drain
      for (int i = 0; i < 17; i++) apb_write(A_DATA, i);
      apb_read(A_STATUS, rd);   check("tx_full_ovf", rd, 32'h46);
      check("tx_head", {24'b0, tx_data}, 32'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("tx_pop%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(i)});
         cyc();
      end
      tx_ready = 1'b0;
      check("tx_drained", {31'b0, tx_valid}, 32'h0);
      apb_read(A_STATUS, rd);   check("tx_empty_status", rd, 32'h45);
      apb_write(A_STATUS, 32'h40);
      apb_read(A_STATUS, rd);   check("tx_ovf_clear", rd, 32'h05);

      // RX window
      rx_valid = 1'b1; rx_data = 8'hA5; cyc();
      rx_data = 8'h3C; cyc();
      rx_valid = 1'b0;
      paddr = A_DATA; #1;
      check("rx_head_a5", prdata, 32'hA5);
      apb_read(A_DATA, rd);     check("rx_read_a5", rd, 32'hA5);
      check("rx_head_3c", prdata, 32'h3C);
      apb_read(A_DATA, rd);     check("rx_read_3c", rd, 32'h3C);
      check("rx_now_empty", prdata, 32'h0);
      apb_read(A_DATA, rd);     check("rx_empty_read", rd, 32'h0);
      apb_read(A_STATUS, rd);   check("rx_empty_status", rd, 32'h05);
      rx_valid = 1'b1; rx_data = 8'h77; cyc(); rx_valid = 1'b0;
      apb_read(A_DATA, rd);     check("rx_after_empty_pop", rd, 32'h77);
      apb_read(A_STATUS, rd);   check("rx_ptr_sane", rd, 32'h05);

      // Push and pop together while empty: push only
      rx_valid = 1'b1; rx_data = 8'h5A;
      apb_read(A_DATA, rd);
      rx_valid = 1'b0;
      check("rx_empty_pushpop", prdata, 32'h5A);
      apb_read(A_DATA, rd);

      // RX overflow, then push+pop while full
      rx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         rx_data = 8'h80 + 8'(i);
         cyc();
      end
      rx_valid = 1'b0;
      apb_read(A_STATUS, rd);   check("rx_full_ovf", rd, 32'h89);
      apb_write(A_STATUS, 32'h80);
      apb_read(A_STATUS, rd);   check("rx_ovf_clear", rd, 32'h09);
      rx_valid = 1'b1; rx_data = 8'hEE;
      apb_read(A_DATA, rd);
      rx_valid = 1'b0;
      check("rx_full_pushpop_rd", rd, 32'h80);
      check("rx_full_pushpop_head", prdata, 32'h81);
      apb_read(A_STATUS, rd);   check("rx_full_pushpop_status", rd, 32'h09);

      // ack_err: set wins over clear in the same cycle
      core_ack_err = 1'b1;
      apb_write(A_STATUS, 32'h20);
      core_ack_err = 1'b0;
      apb_read(A_STATUS, rd);   check("ack_set_wins", rd, 32'h29);
      apb_write(A_STATUS, 32'h20);
      apb_read(A_STATUS, rd);   check("ack_cleared", rd, 32'h09);
      core_busy = 1'b1;
      apb_read(A_STATUS, rd);   check("core_busy", rd, 32'h19);
      core_busy = 1'b0;

      // Reset mid-operation discards FIFO contents
      apb_write(A_DATA, 32'h55);
      check("tx_before_reset", {31'b0, tx_valid}, 32'h1);
      do_reset();
      check("tx_after_reset", {31'b0, tx_valid}, 32'h0);
      apb_read(A_STATUS, rd);   check("status_after_reset", rd, 32'h05);
      apb_read(A_DATA, rd);     check("data_after_reset", rd, 32'h0);
      apb_read(A_PRESC, rd);    check("presc_after_reset", rd, 32'h0063);

`ifdef I2C_REGS_IRQ_EN
      apb_write(A_IRQ_EN, 32'h2);
      apb_read(A_IRQ_EN, rd);   check("irq_en_read", rd, 32'h2);
      rx_valid = 1'b1; rx_data = 8'h11; cyc(); rx_valid = 1'b0;
      check("irq_lag", {31'b0, irq}, 32'h0);
      cyc();
      check("irq_set", {31'b0, irq}, 32'h1);
      apb_read(A_IRQ_STAT, rd); check("irq_stat", rd, 32'h3);
      apb_read(A_DATA, rd);
      check("irq_hold", {31'b0, irq}, 32'h1);
      cyc();
      check("irq_clear", {31'b0, irq}, 32'h0);
      apb_write(A_IRQ_EN, 32'h0);
      cyc();
`endif

      // Randomized traffic against the queue model, starting from reset
      do_reset();
      tx_q.delete(); rx_q.delete();
      m_ack = 0; m_tx_ovf = 0; m_rx_ovf = 0;
      for (int n = 0; n < 800; n++) begin
         int kind;
         bit w_data, r_data, w_stat, tr, rv, ae;
         logic [7:0] wb, rb, clr;
         kind = int'($urandom_range(0, 9));
         w_data = (kind <= 3);
         r_data = (kind == 4 || kind == 5);
         w_stat = (kind == 6);
         tr = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 9) < 4);
         ae = ($urandom_range(0, 19) == 0);
         wb = 8'($urandom);
         rb = 8'($urandom);
         clr = 8'($urandom);
         psel = w_data | r_data | w_stat;
         penable = psel;
         pwrite = w_data | w_stat;
         paddr = w_stat ? A_STATUS : ((w_data | r_data) ? A_DATA :
                 ($urandom_range(0, 1) == 0 ? A_DATA : A_STATUS));
         pwdata = w_stat ? {24'b0, clr} : {24'hABCDEF, wb};
         tx_ready = tr; rx_valid = rv; rx_data = rb; core_ack_err = ae;
         core_busy = ($urandom_range(0, 1) == 0);
         #1;
         check("rnd_tx_valid", {31'b0, tx_valid}, {31'b0, tx_q.size() != 0});
         if (tx_q.size() != 0) check("rnd_tx_data", {24'b0, tx_data}, {24'b0, tx_q[0]});
         if (paddr == A_DATA)
            check("rnd_data", prdata, (rx_q.size() == 0) ? 32'h0 : {24'b0, rx_q[0]});
         else
            check("rnd_status", prdata, exp_status());
         check("rnd_irq", {31'b0, irq}, 32'h0);
         @(posedge pclk);
         #1;
         begin
            bit tx_pop, rx_pop, tx_ok, rx_ok;
            tx_pop = tr && (tx_q.size() > 0);
            tx_ok  = w_data && (tx_q.size() < DEPTH || tx_pop);
            rx_pop = r_data && (rx_q.size() > 0);
            rx_ok  = rv && (rx_q.size() < DEPTH || rx_pop);
            m_ack    = ae | (m_ack & !(w_stat && clr[5]));
            m_tx_ovf = (w_data && !tx_ok) | (m_tx_ovf & !(w_stat && clr[6]));
            m_rx_ovf = (rv && !rx_ok) | (m_rx_ovf & !(w_stat && clr[7]));
            if (tx_pop) void'(tx_q.pop_front());
            if (tx_ok)  tx_q.push_back(wb);
            if (rx_pop) void'(rx_q.pop_front());
            if (rx_ok)  rx_q.push_back(rb);
         end
      end
      psel = 0; penable = 0; pwrite = 0; tx_ready = 0; rx_valid = 0; core_ack_err = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
